// File: rtl/data_mem_responder.sv
// Data-memory responder: req/ready handshake, WAIT_CYCLES wait states, byte/half/word lanes.
// Optional macro DMEM_FAULT_EN flags misaligned/out-of-range accesses instead of aligning/wrapping.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned_ld,
    output logic        o_ready,
    output logic [31:0] o_rdata,
    output logic        o_fault
);
    localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WaitLast = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state, w_state_d;
    logic [3:0]  r_cnt, w_cnt_d;
    logic        r_we, r_uns;
    logic [31:0] r_addr, r_wdata;
    logic [1:0]  r_size;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [29:0]     w_word;
    logic            w_is_byte, w_is_half;
    logic            w_fault;
    logic [1:0]      w_off;
    logic [IdxW-1:0] w_idx;
    logic [3:0]      w_wmask;
    logic [31:0]     w_wdata_lane;
    logic [31:0]     w_rword;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (r_state == StIdle && i_req) begin
                r_we    <= i_we;
                r_uns   <= i_unsigned_ld;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
                r_size  <= i_size;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        case (r_state)
            StIdle: begin
                if (i_req) begin
                    w_state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
                end
            end
            StWait: begin
                w_cnt_d = r_cnt + 4'd1;
                if (w_cnt_d == WaitLast) begin
                    w_state_d = StResp;
                    w_cnt_d   = '0;
                end
            end
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    assign w_word    = r_addr[31:2];
    assign w_is_byte = (r_size == 2'b00);
    assign w_is_half = (r_size == 2'b01);

`ifdef DMEM_FAULT_EN
    logic w_misaligned, w_oor;
    assign w_misaligned = (w_is_half && r_addr[0]) || (r_size[1] && (r_addr[1:0] != 2'b00));
    assign w_oor        = ({2'b00, w_word} >= DEPTH_WORDS);
    assign w_fault      = w_misaligned | w_oor;
    assign w_off        = r_addr[1:0];
`else
    assign w_fault = 1'b0;
    // Force-align: half ignores addr[0], word ignores addr[1:0]
    assign w_off   = r_size[1] ? 2'b00 : (w_is_half ? {r_addr[1], 1'b0} : r_addr[1:0]);
`endif

    // In-range indices are unchanged by the modulo; out-of-range ones wrap
    assign w_idx = IdxW'({2'b00, w_word} % DEPTH_WORDS);

    always_comb begin
        w_wmask      = 4'b1111;
        w_wdata_lane = r_wdata;
        if (w_is_byte) begin
            w_wmask      = 4'b0001 << w_off;
            w_wdata_lane = {4{r_wdata[7:0]}};
        end else if (w_is_half) begin
            w_wmask      = w_off[1] ? 4'b1100 : 4'b0011;
            w_wdata_lane = {2{r_wdata[15:0]}};
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_state == StResp && r_we && !w_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wmask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_lane[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rword = r_mem[w_idx] >> {w_off, 3'b000};
        o_ready = (r_state == StResp);
        o_fault = 1'b0;
        o_rdata = '0;
        if (r_state == StResp) begin
            o_fault = w_fault;
            if (!r_we && !w_fault) begin
                if (w_is_byte) begin
                    o_rdata = {{24{~r_uns & w_rword[7]}}, w_rword[7:0]};
                end else if (w_is_half) begin
                    o_rdata = {{16{~r_uns & w_rword[15]}}, w_rword[15:0]};
                end else begin
                    o_rdata = w_rword;
                end
            end
        end
    end

endmodule
